// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch controller: takes FTQ blocks, issues one ICache read each, buffers live responses for the IB.
// Optional macro IFU_RESP_BYPASS_EN: a live response reaches ib_* combinationally when the FIFO is empty.

package ifu_fetch_ctrl_pkg;
  localparam int unsigned IFU_ADDR_W  = 32;
  localparam int unsigned IFU_FETCH_W = 4;
  localparam int unsigned IFU_LEN_W   = $clog2(IFU_FETCH_W + 1);

  typedef struct packed {
    logic                  valid;
    logic [IFU_ADDR_W-1:0] start_pc;
    logic [IFU_LEN_W-1:0]  length;
    logic                  is_cross_cacheline;
  } ftq_block_t;
endpackage

module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IFU_ADDR_W,
  parameter int unsigned FETCH_WIDTH = IFU_FETCH_W,
  parameter int unsigned FTQ_SIZE    = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  ftq_block_t                        ftq_i,
  input  logic [$clog2(FTQ_SIZE)-1:0]       ftq_id_i,
  output logic                              ftq_accept_o,
  input  logic                              ftq_redirect_i,
  input  logic                              backend_flush_i,
  output logic                              icache_req_valid_o,
  input  logic                              icache_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             icache_req_addr_o,
  output logic                              icache_req_cross_o,
  input  logic                              icache_resp_valid_i,
  input  logic [FETCH_WIDTH*32-1:0]         icache_resp_data_i,
  output logic [FETCH_WIDTH-1:0]            ib_valid_o,
  output logic [FETCH_WIDTH*ADDR_WIDTH-1:0] ib_pc_o,
  output logic [FETCH_WIDTH*32-1:0]         ib_instr_o,
  output logic [FETCH_WIDTH-1:0]            ib_last_o,
  output logic [$clog2(FTQ_SIZE)-1:0]       ib_ftq_id_o,
  input  logic                              ib_ready_i
);

  localparam int unsigned ID_W   = $clog2(FTQ_SIZE);
  localparam int unsigned LEN_W  = IFU_LEN_W;
  localparam int unsigned PC_W   = FETCH_WIDTH * ADDR_WIDTH;
  localparam int unsigned DATA_W = FETCH_WIDTH * 32;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] valid;
    logic [PC_W-1:0]        pc;
    logic [DATA_W-1:0]      instr;
    logic [FETCH_WIDTH-1:0] last;
    logic [ID_W-1:0]        id;
  } bundle_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ID_W-1:0]       inf_id_q, inf_id_d;
  logic [ADDR_WIDTH-1:0] inf_pc_q, inf_pc_d;
  logic [LEN_W-1:0]      inf_len_q, inf_len_d;
  bundle_t               fifo_q [0:1];
  bundle_t               fifo_d [0:1];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            cnt_q, cnt_d;

  bundle_t    resp_bundle;
  bundle_t    ib_out;
  logic       inflight, resp_take, resp_live, resp_drop, fifo_empty;
  logic       byp_cand, byp_show, pop_credit, fifo_pop, push, slot_free, accept;
  logic [2:0] occ;

  // Expand the in-flight block and the response data into lane form.
  always_comb begin
    resp_bundle    = '0;
    resp_bundle.id = inf_id_q;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (i < 32'(inf_len_q)) begin
        resp_bundle.valid[i]                       = 1'b1;
        resp_bundle.pc[i*ADDR_WIDTH +: ADDR_WIDTH] = inf_pc_q + ADDR_WIDTH'(4 * i);
        resp_bundle.instr[i*32 +: 32]              = icache_resp_data_i[i*32 +: 32];
      end
      if (32'(inf_len_q) == i + 1) resp_bundle.last[i] = 1'b1;
    end
  end

  assign inflight   = (state_q != S_IDLE);
  assign resp_take  = inflight & icache_resp_valid_i;
  assign resp_live  = (state_q == S_WAIT) & icache_resp_valid_i;
  assign resp_drop  = (state_q == S_DROP) & icache_resp_valid_i;
  assign fifo_empty = (cnt_q == 2'd0);

`ifdef IFU_RESP_BYPASS_EN
  assign byp_cand = fifo_empty & resp_live;
`else
  assign byp_cand = 1'b0;
`endif
  assign byp_show = byp_cand & ~ftq_redirect_i & ~backend_flush_i;

  always_comb begin
    ib_out = '0;
    if (byp_show)         ib_out = resp_bundle;
    else if (!fifo_empty) ib_out = fifo_q[rd_ptr_q];
  end

  assign ib_valid_o  = ib_out.valid;
  assign ib_pc_o     = ib_out.pc;
  assign ib_instr_o  = ib_out.instr;
  assign ib_last_o   = ib_out.last;
  assign ib_ftq_id_o = ib_out.id;

  // Occupancy the FIFO is committed to after this cycle; redirect is deliberately not a term.
  assign pop_credit = ib_ready_i & (~fifo_empty | byp_cand);
  assign occ        = 3'(cnt_q) + 3'(inflight) - 3'(pop_credit) - 3'(resp_drop);
  assign slot_free  = (~inflight | resp_take) & (occ < 3'd2);
  assign accept     = rst_n & ftq_i.valid & icache_req_ready_i & ~backend_flush_i & slot_free;

  assign ftq_accept_o       = accept;
  assign icache_req_valid_o = accept;
  assign icache_req_addr_o  = ADDR_WIDTH'(ftq_i.start_pc);
  assign icache_req_cross_o = ftq_i.is_cross_cacheline;

  assign fifo_pop = ib_ready_i & ~fifo_empty;
  assign push     = resp_live & ~ftq_redirect_i & ~backend_flush_i & ~(byp_show & ib_ready_i);

  // Next state, in-flight tracking and FIFO update.
  always_comb begin
    state_d   = state_q;
    inf_id_d  = inf_id_q;
    inf_pc_d  = inf_pc_q;
    inf_len_d = inf_len_q;
    fifo_d    = fifo_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;

    if (backend_flush_i) begin
      state_d = (inflight & ~icache_resp_valid_i) ? S_DROP : S_IDLE;
    end else if (ftq_redirect_i) begin
      state_d = (accept | (inflight & ~icache_resp_valid_i)) ? S_DROP : S_IDLE;
    end else if (accept) begin
      state_d = S_WAIT;
    end else if (resp_take) begin
      state_d = S_IDLE;
    end

    if (accept) begin
      inf_id_d  = ftq_id_i;
      inf_pc_d  = ADDR_WIDTH'(ftq_i.start_pc);
      inf_len_d = ftq_i.length;
    end

    if (backend_flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = resp_bundle;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (fifo_pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      inf_id_q  <= '0;
      inf_pc_q  <= '0;
      inf_len_q <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      inf_id_q  <= inf_id_d;
      inf_pc_q  <= inf_pc_d;
      inf_len_q <= inf_len_d;
      fifo_q    <= fifo_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
